// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit display scan controller.
// Provides the FSM state encoding, digit select codes and the anode decode helper.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam int          NUM_DIGITS = 4;
    localparam logic [3:0]  AN_OFF     = 4'hF;

    localparam logic [1:0]  COM = 2'b00;
    localparam logic [1:0]  A   = 2'b01;
    localparam logic [1:0]  B   = 2'b10;
    localparam logic [1:0]  C   = 2'b11;

    // Active-low one-hot anode pattern for a given digit select.
    function automatic logic [3:0] an_onehot(input logic [1:0] sel);
        logic [3:0] an;
        case (sel)
            COM:     an = 4'hE;
            A:       an = 4'hD;
            B:       an = 4'hB;
            default: an = 4'h7;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_next_digit.sv
// Rotating-priority search for the next enabled digit strictly after cur,
// wrapping 3 -> 0 and finally landing on cur itself if only that bit is set.
module scan_next_digit
    import scan_pkg::*;
(
    input  logic [1:0] cur,
    input  logic [3:0] mask,
    output logic [1:0] nxt,
    output logic       valid,
    output logic       wrap
);

    // Candidate gi sits gi+1 positions after cur; bit 2 of the sum marks a wrap past digit 3.
    logic [2:0] sum_w [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] hit_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_cand
            assign sum_w[gi] = {1'b0, cur} + 3'(gi + 1);
            assign hit_w[gi] = mask[sum_w[gi][1:0]];
        end
    endgenerate

    always_comb begin
        nxt   = cur;
        valid = 1'b0;
        wrap  = 1'b0;
        // Walk from the farthest candidate inward so the nearest hit wins.
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (hit_w[k]) begin
                nxt   = sum_w[k][1:0];
                valid = 1'b1;
                wrap  = sum_w[k][2];
            end
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexing scheduler for a 4-digit display: each enabled digit gets a blank gap
// followed by a lit period, with a frame_done pulse whenever the scan wraps around.
module display_scan_ctrl
    import scan_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       blank,
    output logic       frame_done
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic             blank_q, blank_d;
    logic             fd_q, fd_d;

    logic [1:0] search_cur;
    logic [1:0] nxt;
    logic       nxt_valid;
    logic       nxt_wrap;

    // Searching from digit 3 in IDLE yields the lowest enabled digit for a fresh start.
    assign search_cur = (state_q == IDLE) ? C : sel_q;

    scan_next_digit u_next (
        .cur   (search_cur),
        .mask  (digit_mask),
        .nxt   (nxt),
        .valid (nxt_valid),
        .wrap  (nxt_wrap)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        fd_d    = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (nxt_valid) begin
                        sel_d   = nxt;
                        cnt_d   = '0;
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (nxt_valid) begin
                            sel_d   = nxt;
                            state_d = BLANK;
                            fd_d    = nxt_wrap;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        an_d    = (state_d == SHOW) ? an_onehot(sel_d) : AN_OFF;
        blank_d = (state_d != SHOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= COM;
            an_q    <= AN_OFF;
            blank_q <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            blank_q <= blank_d;
            fd_q    <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a digit-level model queues the expected lit
// digits; a monitor reconstructs each lit digit from the outputs and compares.
module tb_display_scan_ctrl;

    localparam int TB_DIV   = 4;
    localparam int TB_BLANK = 1;
    localparam int P        = TB_DIV + TB_BLANK;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] digit_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic       blank;
    logic       frame_done;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [1:0] sel;
        int         lit;
        bit         fd;
        bit         chk_gap;
    } exp_t;

    exp_t sb_q[$];

    display_scan_ctrl #(.CLK_DIV(TB_DIV), .BLANK_CYC(TB_BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel),
        .an         (an),
        .blank      (blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_an(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    // Next enabled digit strictly after cur (wrapping), cur itself as last resort.
    function automatic void next_after(input int cur, input logic [3:0] m,
                                       output int nx, output bit wr, output bit ok);
        ok = 1'b0;
        nx = cur;
        wr = 1'b0;
        for (int j = 4; j >= 1; j--) begin
            if (m[(cur + j) % 4]) begin
                nx = (cur + j) % 4;
                wr = (cur + j) >= 4;
                ok = 1'b1;
            end
        end
    endfunction

    // One scan session: enable with m0, optionally switch to m1 after edge chg_edge,
    // and end either after n full digits or by dropping en trunc_len cycles into digit n-1.
    task automatic run_phase(input logic [3:0] m0, input int n, input int chg_edge,
                             input logic [3:0] m1, input int trunc_len);
        int  cur, nx, de;
        bit  wr, ok;
        exp_t e;
        logic [3:0] meff;
        next_after(3, m0, cur, wr, ok);
        for (int k = 0; k < n; k++) begin
            meff = (chg_edge > 0 && (1 + P * (k + 1)) > chg_edge) ? m1 : m0;
            next_after(cur, meff, nx, wr, ok);
            e.sel     = 2'(cur);
            e.lit     = (trunc_len > 0 && k == n - 1) ? trunc_len : TB_DIV;
            e.fd      = (trunc_len > 0 && k == n - 1) ? 1'b0 : wr;
            e.chk_gap = (k > 0);
            sb_q.push_back(e);
            cur = nx;
        end
        de = (trunc_len > 0) ? (1 + P * (n - 1) + TB_BLANK + trunc_len) : (1 + P * n + 1);
        $display("[TB] phase mask=%h n=%0d chg@%0d->%h trunc=%0d", m0, n, chg_edge, m1, trunc_len);
        @(negedge clk);
        digit_mask = m0;
        en         = 1'b1;
        for (int edge_i = 1; edge_i < de; edge_i++) begin
            @(negedge clk);
            if (edge_i == chg_edge) digit_mask = m1;
            if (edge_i == de - 1)   en = 1'b0;
        end
        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: rebuilds each lit digit from the outputs and checks it against the queue.
    initial begin
        logic       prev_blank;
        int         lit_cnt, gap_cnt, last_gap;
        logic [1:0] cur_sel;
        logic [3:0] cur_an;
        bit         bad;
        exp_t       e;
        prev_blank = 1'b1;
        lit_cnt = 0; gap_cnt = 0; last_gap = 0;
        cur_sel = '0; cur_an = '0; bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_blank = 1'b1;
                gap_cnt    = 0;
            end else if (blank === 1'b0) begin
                if (prev_blank) begin
                    cur_sel  = sel;
                    cur_an   = an;
                    lit_cnt  = 1;
                    last_gap = gap_cnt;
                    bad      = 1'b0;
                end else begin
                    lit_cnt++;
                    if (sel !== cur_sel || an !== cur_an) bad = 1'b1;
                end
                if (an !== exp_an(sel)) bad = 1'b1;
                if (frame_done !== 1'b0) chk("frame_done_while_lit", frame_done, 0);
                prev_blank = 1'b0;
            end else begin
                chk("an_off_while_blank", an, 4'hF);
                if (!prev_blank) begin
                    chk("sb_nonempty", sb_q.size() > 0, 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        $display("[TB] digit sel=%0d an=%h lit=%0d gap=%0d fd=%0b (exp sel=%0d lit=%0d fd=%0b)",
                                 cur_sel, cur_an, lit_cnt, last_gap, frame_done, e.sel, e.lit, e.fd);
                        chk("digit_sel", cur_sel, e.sel);
                        chk("digit_an", cur_an, exp_an(e.sel));
                        chk("lit_cycles", lit_cnt, e.lit);
                        chk("frame_done", frame_done, e.fd);
                        chk("lit_stable_onehot", bad, 0);
                        if (e.chk_gap) chk("blank_gap", last_gap, TB_BLANK);
                    end
                    gap_cnt = 1;
                end else begin
                    gap_cnt++;
                    if (frame_done !== 1'b0) chk("spurious_frame_done", frame_done, 0);
                end
                prev_blank = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, m1, n, mode, chg, tl;
        rst = 1'b1; en = 1'b0; digit_mask = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_sel", sel, 0);
        chk("reset_blank", blank, 1);
        chk("reset_fd", frame_done, 0);
        rst = 1'b0;

        // Async reset while digit 2 is lit.
        @(negedge clk);
        en = 1'b1; digit_mask = 4'hF;
        repeat (13) @(posedge clk);
        #1;
        chk("pre_reset_an_digit2", an, 4'hB);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_an", an, 4'hF);
        chk("async_reset_sel", sel, 0);
        chk("async_reset_blank", blank, 1);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset_an", an, 4'hF);
            chk("idle_after_reset_fd", frame_done, 0);
        end
        mon_en = 1'b1;

        // Empty mask with enable: stays dark.
        en = 1'b1; digit_mask = 4'h0;
        repeat (10) begin
            @(negedge clk);
            chk("empty_mask_an", an, 4'hF);
            chk("empty_mask_blank", blank, 1);
        end
        en = 1'b0;
        @(negedge clk);

        run_phase(4'hF, 8, 0, 4'h0, 0);      // full scan, two frames
        run_phase(4'b1010, 6, 0, 4'h0, 0);   // sparse mask
        run_phase(4'b0100, 4, 0, 4'h0, 0);   // single digit
        run_phase(4'hF, 3, 0, 4'h0, 2);      // en drop during digit 2
        run_phase(4'hF, 2, 0, 4'h0, 0);      // re-enable restarts at digit 0
        run_phase(4'hF, 4, 7, 4'b0001, 0);   // mask change during digit 1

        for (int r = 0; r < 10; r++) begin
            m0   = $urandom_range(1, 15);
            n    = $urandom_range(1, 6);
            mode = $urandom_range(0, 2);
            chg  = 0; m1 = 0; tl = 0;
            if (mode == 1) begin
                chg = $urandom_range(1, P * n);
                m1  = $urandom_range(1, 15);
            end else if (mode == 2) begin
                tl = $urandom_range(1, TB_DIV - 1);
            end
            run_phase(4'(m0), n, chg, 4'(m1), tl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
